sha2_message_scheduler: RTL



---
 rtl/sha2_pkg.sv | 44 ++++
 rtl/sha2_message_scheduler_if.sv | 27 ++
 rtl/sha2_sched_expand.sv | 24 ++
 rtl/sha2_message_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// SHA-2 message-schedule shared types, constants and sigma helpers.
// Word-width-generic small sigmas for SHA-224/256 and SHA-384/512.
package sha2_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_WORD_W = 64;
  localparam int SHA512_ROUNDS = 80;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Values are carried in 64 bits; narrower words sit in the low bits.
  function automatic logic [63:0] rotr(
    input logic [63:0] x,
    input int          n,
    input int          w
  );
    logic [63:0] m;
    m = (w == 64) ? '1 : 64'h0000_0000_ffff_ffff;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] sigma0(
    input logic [63:0] x,
    input int          w
  );
    if (w == 64)
      return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sigma1(
    input logic [63:0] x,
    input int          w
  );
    if (w == 64)
      return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha2_message_scheduler_if.sv
// Block-in / schedule-word-out handshake bundle for the scheduler.
// slave = scheduler side, master = producer/consumer side.
interface sha2_message_scheduler_if #(
  parameter int WORD_W = 32,
  parameter int RND_W  = 6
);
  logic [16*WORD_W-1:0] blk_i;
  logic                 blk_valid_i;
  logic                 blk_ready_o;
  logic [WORD_W-1:0]    wt_o;
  logic                 wt_valid_o;
  logic                 wt_ready_i;
  logic [RND_W-1:0]     wt_round_o;
  logic                 wt_last_o;

  modport slave (
    input  blk_i, blk_valid_i, wt_ready_i,
    output blk_ready_o, wt_o, wt_valid_o,
    output wt_round_o, wt_last_o
  );

  modport master (
    output blk_i, blk_valid_i, wt_ready_i,
    input  blk_ready_o, wt_o, wt_valid_o,
    input  wt_round_o, wt_last_o
  );
endinterface

// File: rtl/sha2_sched_expand.sv
// Combinational SHA-2 schedule step: next = s1(w14)+w9+s0(w1)+w0.
// Ports: i_w0/i_w1/i_w9/i_w14 window taps in, o_next new word out.
module sha2_sched_expand
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] i_w0,
  input  logic [WORD_W-1:0] i_w1,
  input  logic [WORD_W-1:0] i_w9,
  input  logic [WORD_W-1:0] i_w14,
  output logic [WORD_W-1:0] o_next
);
  logic [63:0] w_s0;
  logic [63:0] w_s1;
  logic [63:0] w_sum;

  always_comb begin
    w_s0   = sigma0(64'(i_w1), WORD_W);
    w_s1   = sigma1(64'(i_w14), WORD_W);
    w_sum  = w_s1 + 64'(i_w9) + w_s0 + 64'(i_w0);
    o_next = w_sum[WORD_W-1:0];
  end
endmodule

// File: rtl/sha2_message_scheduler.sv
// SHA-2 message scheduler: takes a 16-word block, streams W[0..ROUNDS-1].
// Ports: clk_i, reset_n_i, flush_i, busy_o, bus (blk in / wt out).
// Option: SHA2_MSG_SCHED_DBUF_EN adds a holding buffer for zero-bubble blocks.
module sha2_message_scheduler
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int RND_W  = $clog2(ROUNDS)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic flush_i,
  output logic busy_o,
  sha2_message_scheduler_if.slave bus
);
  if (WORD_W != SHA256_WORD_W && WORD_W != SHA512_WORD_W) begin : g_bad_w
    $error("sha2_message_scheduler: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > SHA512_ROUNDS) begin : g_bad_r
    $error("sha2_message_scheduler: ROUNDS must be 16..80");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WORD_W-1:0]    r_win [16];
  logic [RND_W-1:0]     r_t;
  logic [WORD_W-1:0]    w_next;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_end;
  logic                 w_ready;
  logic                 w_acc;
  logic                 w_load;
  logic [16*WORD_W-1:0] w_src;

  assign w_hs   = (r_state == RUN) & bus.wt_ready_i;
  assign w_last = (r_t == RND_W'(ROUNDS - 1));
  assign w_end  = w_hs & w_last;
  assign w_acc  = bus.blk_valid_i & w_ready;

`ifdef SHA2_MSG_SCHED_DBUF_EN
  logic [16*WORD_W-1:0] r_buf;
  logic                 r_buf_full;
  logic                 w_acc_win;
  logic                 w_reload;

  assign w_ready   = ~r_buf_full & ~flush_i;
  // Window is free in IDLE or when the last word leaves with no block queued.
  assign w_acc_win = w_acc & ((r_state == IDLE) | w_end);
  assign w_reload  = w_end & r_buf_full & ~flush_i;
  assign w_load    = w_acc_win | w_reload;
  assign w_src     = r_buf_full ? r_buf : bus.blk_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (flush_i) begin
      r_buf_full <= 1'b0;
    end else if (w_reload) begin
      r_buf_full <= 1'b0;
    end else if (w_acc & ~w_acc_win) begin
      r_buf      <= bus.blk_i;
      r_buf_full <= 1'b1;
    end
  end
`else
  assign w_ready = (r_state == IDLE) & ~flush_i;
  assign w_load  = w_acc;
  assign w_src   = bus.blk_i;
`endif

  sha2_sched_expand #(
    .WORD_W (WORD_W)
  ) u_expand (
    .i_w0   (r_win[0]),
    .i_w1   (r_win[1]),
    .i_w9   (r_win[9]),
    .i_w14  (r_win[14]),
    .o_next (w_next)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_acc) w_state_nxt = RUN;
`ifdef SHA2_MSG_SCHED_DBUF_EN
        RUN:  if (w_end & ~w_load) w_state_nxt = IDLE;
`else
        RUN:  if (w_end) w_state_nxt = IDLE;
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o          = (r_state == RUN);
    bus.wt_valid_o  = (r_state == RUN);
    bus.wt_o        = r_win[0];
    bus.wt_round_o  = r_t;
    bus.wt_last_o   = w_last & (r_state == RUN);
    bus.blk_ready_o = w_ready;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < 16; k++) r_win[k] <= '0;
      r_t <= '0;
    end else if (flush_i) begin
      r_t <= '0;
    end else if (w_load) begin
      for (int k = 0; k < 16; k++)
        r_win[k] <= w_src[(15-k)*WORD_W +: WORD_W];
      r_t <= '0;
    end else if (w_hs) begin
      for (int k = 0; k < 15; k++) r_win[k] <= r_win[k+1];
      r_win[15] <= w_next;
      r_t <= w_last ? '0 : r_t + RND_W'(1);
    end
  end
endmodule
